// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute and drives the
// datapath mux selects, write enables and ALUControl for each state.
module multicycle_control #(
  parameter bit SUPPORT_ADDI = 1'b1,
  parameter bit SUPPORT_J    = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [1:0] PCSrc,
  output logic       PCEn,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXECUTE = 4'd6,
    ALUWB   = 4'd7,
    BRANCH  = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JUMP    = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  state_t state_q, state_d;

  always_ff @(posedge clk) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  assign state = state_q;

  always_comb begin
    state_d    = FETCH;
    IorD       = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    RegWrite   = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ALUControl = 3'b000;
    PCSrc      = 2'b00;
    PCEn       = 1'b0;
    illegal    = 1'b0;
    case (state_q)
      FETCH: begin
        IRWrite = 1'b1;
        ALUSrcB = 2'b01;
        PCEn    = 1'b1;
        state_d = DECODE;
      end
      DECODE: begin
        // Branch target is precomputed here so BRANCH only needs the compare.
        ALUSrcB = 2'b11;
        case (op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = EXECUTE;
          OP_BEQ:       state_d = BRANCH;
          OP_ADDI: begin
            if (SUPPORT_ADDI) state_d = ADDIEX;
            else              illegal = 1'b1;
          end
          OP_J: begin
            if (SUPPORT_J) state_d = JUMP;
            else           illegal = 1'b1;
          end
          default: illegal = 1'b1;
        endcase
      end
      MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = (op == OP_SW) ? MEMWR : MEMRD;
      end
      MEMRD: begin
        IorD    = 1'b1;
        state_d = MEMWB;
      end
      MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      MEMWR: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
      end
      EXECUTE: begin
        ALUSrcA = 1'b1;
        case (funct)
          6'b100000: ALUControl = 3'b000;
          6'b100010: ALUControl = 3'b001;
          6'b100100: ALUControl = 3'b010;
          6'b100101: ALUControl = 3'b011;
          default:   ALUControl = 3'b111;
        endcase
        state_d = ALUWB;
      end
      ALUWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      BRANCH: begin
        ALUSrcA    = 1'b1;
        ALUControl = 3'b001;
        PCSrc      = 2'b01;
        PCEn       = zero;
      end
      ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = ADDIWB;
      end
      ADDIWB: begin
        RegWrite = 1'b1;
      end
      JUMP: begin
        PCSrc = 2'b10;
        PCEn  = 1'b1;
      end
      default: state_d = FETCH;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: random instruction streams on two parameter
// variants, every cycle's outputs scored against a per-instruction model.
module tb_multicycle_control;

  // Handshake: the driver pushes one expected word per cycle of an instruction
  // before that instruction's FETCH cycle; each monitor pops one word on every
  // falling edge while its enable is high and compares it to the DUT outputs.

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  logic clk = 1'b0;
  logic reset0 = 1'b1, reset1 = 1'b1;
  logic [5:0] op0 = '0, funct0 = '0, op1 = '0, funct1 = '0;
  logic zero0 = 1'b0, zero1 = 1'b0;
  logic mon_en0 = 1'b0, mon_en1 = 1'b0;
  logic done0 = 1'b0, done1 = 1'b0;

  logic       iord0, mw0, irw0, rd0, m2r0, rw0, sa0, pcen0, ill0;
  logic [1:0] sb0, pcs0;
  logic [2:0] alc0;
  logic [3:0] st0;
  logic       iord1, mw1, irw1, rd1, m2r1, rw1, sa1, pcen1, ill1;
  logic [1:0] sb1, pcs1;
  logic [2:0] alc1;
  logic [3:0] st1;

  logic [19:0] exp0_q[$];
  logic [19:0] exp1_q[$];
  logic [19:0] got0, want0, got1, want1;
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  multicycle_control dut0 (
    .clk(clk), .reset(reset0), .op(op0), .funct(funct0), .zero(zero0),
    .IorD(iord0), .MemWrite(mw0), .IRWrite(irw0), .RegDst(rd0),
    .MemtoReg(m2r0), .RegWrite(rw0), .ALUSrcA(sa0), .ALUSrcB(sb0),
    .ALUControl(alc0), .PCSrc(pcs0), .PCEn(pcen0), .illegal(ill0), .state(st0)
  );

  multicycle_control #(.SUPPORT_ADDI(1'b0), .SUPPORT_J(1'b0)) dut1 (
    .clk(clk), .reset(reset1), .op(op1), .funct(funct1), .zero(zero1),
    .IorD(iord1), .MemWrite(mw1), .IRWrite(irw1), .RegDst(rd1),
    .MemtoReg(m2r1), .RegWrite(rw1), .ALUSrcA(sa1), .ALUSrcB(sb1),
    .ALUControl(alc1), .PCSrc(pcs1), .PCEn(pcen1), .illegal(ill1), .state(st1)
  );

  // ---------------- reference model ----------------
  function automatic int path_len(input logic [5:0] o, input bit s_addi, input bit s_j);
    case (o)
      OP_LW:    return 5;
      OP_SW:    return 4;
      OP_RTYPE: return 4;
      OP_BEQ:   return 3;
      OP_ADDI:  return s_addi ? 4 : 2;
      OP_J:     return s_j ? 3 : 2;
      default:  return 2;
    endcase
  endfunction

  function automatic int path_state(input logic [5:0] o, input int k);
    if (k < 2) return k;
    case (o)
      OP_LW:    return k + 0;          // 2,3,4
      OP_SW:    return (k == 2) ? 2 : 5;
      OP_RTYPE: return (k == 2) ? 6 : 7;
      OP_BEQ:   return 8;
      OP_ADDI:  return (k == 2) ? 9 : 10;
      default:  return 11;
    endcase
  endfunction

  function automatic logic [2:0] alu_of(input logic [5:0] f);
    case (f)
      6'b100000: return 3'b000;
      6'b100010: return 3'b001;
      6'b100100: return 3'b010;
      6'b100101: return 3'b011;
      default:   return 3'b111;
    endcase
  endfunction

  // Word layout: state, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
  // ALUSrcA, ALUSrcB, ALUControl, PCSrc, PCEn, illegal.
  function automatic logic [19:0] exp_vec(input int st, input logic [5:0] f,
                                          input logic z, input logic ill);
    logic iord, mw, irw, rd, m2r, rw, sa, pcen, il;
    logic [1:0] sb, pcs;
    logic [2:0] alc;
    logic [3:0] s4;
    iord = 0; mw = 0; irw = 0; rd = 0; m2r = 0; rw = 0; sa = 0; pcen = 0;
    sb = 2'b00; pcs = 2'b00; alc = 3'b000; il = 0;
    s4 = 4'(st);
    case (st)
      0:  begin irw = 1; sb = 2'b01; pcen = 1; end
      1:  begin sb = 2'b11; il = ill; end
      2:  begin sa = 1; sb = 2'b10; end
      3:  iord = 1;
      4:  begin rw = 1; m2r = 1; end
      5:  begin iord = 1; mw = 1; end
      6:  begin sa = 1; alc = alu_of(f); end
      7:  begin rw = 1; rd = 1; end
      8:  begin sa = 1; alc = 3'b001; pcs = 2'b01; pcen = z; end
      9:  begin sa = 1; sb = 2'b10; end
      10: rw = 1;
      11: begin pcs = 2'b10; pcen = 1; end
      default: ;
    endcase
    return {s4, iord, mw, irw, rd, m2r, rw, sa, sb, alc, pcs, pcen, il};
  endfunction

  // ---------------- driver ----------------
  task automatic push_exp(input int which, input logic [19:0] v);
    if (which == 0) exp0_q.push_back(v);
    else            exp1_q.push_back(v);
  endtask

  task automatic run_instr(input int which, input logic [5:0] o,
                           input logic [5:0] f, input logic z);
    bit sa_en, sj_en;
    int len;
    logic ill;
    sa_en = (which == 0);
    sj_en = (which == 0);
    len = path_len(o, sa_en, sj_en);
    ill = (len == 2);
    for (int k = 0; k < len; k++) push_exp(which, exp_vec(path_state(o, k), f, z, ill));
    if (which == 0) begin op0 = o; funct0 = f; zero0 = z; end
    else            begin op1 = o; funct1 = f; zero1 = z; end
    repeat (len) @(posedge clk);
    #1;
  endtask

  task automatic rand_instr(input int which);
    logic [5:0] o, f;
    int r;
    r = $urandom_range(0, 6);
    case (r)
      0: o = OP_LW;
      1: o = OP_SW;
      2: o = OP_RTYPE;
      3: o = OP_BEQ;
      4: o = OP_ADDI;
      5: o = OP_J;
      default: o = 6'($urandom_range(0, 63));
    endcase
    r = $urandom_range(0, 4);
    case (r)
      0: f = 6'b100000;
      1: f = 6'b100010;
      2: f = 6'b100100;
      3: f = 6'b100101;
      default: f = 6'($urandom_range(0, 63));
    endcase
    run_instr(which, o, f, 1'($urandom_range(0, 1)));
  endtask

  // lw interrupted by a two-edge reset while in MEMRD
  task automatic lw_with_reset();
    for (int k = 0; k < 4; k++) exp0_q.push_back(exp_vec(k, 6'd0, 1'b0, 1'b0));
    exp0_q.push_back(exp_vec(0, 6'd0, 1'b0, 1'b0));
    op0 = OP_LW; funct0 = 6'd0; zero0 = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset0 = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset0 = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 reset0 = 1'b0;
    mon_en0 = 1'b1;
    lw_with_reset();
    run_instr(0, OP_LW, 6'd0, 1'b0);
    run_instr(0, OP_SW, 6'd0, 1'b1);
    run_instr(0, OP_RTYPE, 6'b100010, 1'b0);
    run_instr(0, OP_RTYPE, 6'b101010, 1'b1);
    run_instr(0, OP_BEQ, 6'd0, 1'b1);
    run_instr(0, OP_BEQ, 6'd0, 1'b0);
    run_instr(0, 6'b111111, 6'd0, 1'b0);
    run_instr(0, OP_J, 6'd0, 1'b0);
    run_instr(0, OP_ADDI, 6'd0, 1'b0);
    for (int i = 0; i < 200; i++) rand_instr(0);
    mon_en0 = 1'b0;
    done0 = 1'b1;
  end

  initial begin
    repeat (4) @(posedge clk);
    #1 reset1 = 1'b0;
    mon_en1 = 1'b1;
    run_instr(1, OP_J, 6'd0, 1'b1);
    run_instr(1, OP_ADDI, 6'd0, 1'b0);
    run_instr(1, OP_LW, 6'd0, 1'b0);
    run_instr(1, OP_BEQ, 6'd0, 1'b1);
    for (int i = 0; i < 80; i++) rand_instr(1);
    mon_en1 = 1'b0;
    done1 = 1'b1;
  end

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    if (mon_en0) begin
      got0 = {st0, iord0, mw0, irw0, rd0, m2r0, rw0, sa0, sb0, alc0, pcs0, pcen0, ill0};
      n_checks++;
      if (exp0_q.size() == 0) begin
        n_fail++;
        $display("FAIL dut0_underflow: got %h, no expected word", got0);
      end else begin
        want0 = exp0_q.pop_front();
        if (got0 !== want0) begin
          n_fail++;
          $display("FAIL dut0_cycle t=%0t: got %h required %h", $time, got0, want0);
        end
      end
      if (mw0 && rw0) begin
        n_fail++;
        $display("FAIL dut0_mw_rw_overlap: MemWrite=%b RegWrite=%b required not both", mw0, rw0);
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en1) begin
      got1 = {st1, iord1, mw1, irw1, rd1, m2r1, rw1, sa1, sb1, alc1, pcs1, pcen1, ill1};
      n_checks++;
      if (exp1_q.size() == 0) begin
        n_fail++;
        $display("FAIL dut1_underflow: got %h, no expected word", got1);
      end else begin
        want1 = exp1_q.pop_front();
        if (got1 !== want1) begin
          n_fail++;
          $display("FAIL dut1_cycle t=%0t: got %h required %h", $time, got1, want1);
        end
      end
    end
  end

  // ---------------- report ----------------
  initial begin
    fork
      wait (done0 && done1);
      #1000000;
    join_any
    disable fork;
    if (!(done0 && done1)) begin
      n_fail++;
      $display("FAIL timeout: done0=%b done1=%b required both 1", done0, done1);
    end
    repeat (2) @(posedge clk);
    n_checks++;
    if (exp0_q.size() != 0) begin
      n_fail++;
      $display("FAIL dut0_leftover: %0d words left, required 0", exp0_q.size());
    end
    n_checks++;
    if (exp1_q.size() != 0) begin
      n_fail++;
      $display("FAIL dut1_leftover: %0d words left, required 0", exp1_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
